// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the 256-byte S memory in place using a 3-byte key.
// Define KSA_INIT_EN to prepend the identity fill S[i]=i so the whole state setup is one block.
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
`ifdef KSA_INIT_EN
    localparam logic [3:0] ST_FILL  = 4'd1;
`endif
    localparam logic [3:0] ST_RD_I  = 4'd2;
    localparam logic [3:0] ST_LAT_I = 4'd3;
    localparam logic [3:0] ST_RD_J  = 4'd4;
    localparam logic [3:0] ST_LAT_J = 4'd5;
    localparam logic [3:0] ST_WR_I  = 4'd6;
    localparam logic [3:0] ST_WR_J  = 4'd7;
    localparam logic [3:0] ST_DONE  = 4'd8;

    logic [3:0] r_state;
    logic       r_rdy;
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_si;
    logic [1:0] r_kIdx;
    logic [7:0] r_sAddr;
    logic [7:0] r_sWrdata;
    logic       r_sWren;

    logic [7:0] w_keyByte;
    logic [7:0] w_jNext;
    logic [7:0] w_iNext;

    always_comb begin
        w_keyByte = key[23:16];
        case (r_kIdx)
            2'd1:    w_keyByte = key[15:8];
            2'd2:    w_keyByte = key[7:0];
            default: w_keyByte = key[23:16];
        endcase
    end

    assign w_jNext = r_j + s_rddata + w_keyByte;
    assign w_iNext = r_i + 8'd1;

    // IDLE with rdy low is the one-cycle start slot between acceptance and the first memory access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rdy     <= 1'b1;
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_si      <= 8'd0;
            r_kIdx    <= 2'd0;
            r_sAddr   <= 8'd0;
            r_sWrdata <= 8'd0;
            r_sWren   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rdy) begin
                        if (en) begin
                            r_rdy  <= 1'b0;
                            r_i    <= 8'd0;
                            r_j    <= 8'd0;
                            r_kIdx <= 2'd0;
                        end
                    end else begin
`ifdef KSA_INIT_EN
                        r_state   <= ST_FILL;
                        r_sAddr   <= 8'd0;
                        r_sWrdata <= 8'd0;
                        r_sWren   <= 1'b1;
`else
                        r_state   <= ST_RD_I;
                        r_sAddr   <= 8'd0;
`endif
                    end
                end
`ifdef KSA_INIT_EN
                ST_FILL: begin
                    if (r_i == 8'hFF) begin
                        r_i     <= 8'd0;
                        r_sAddr <= 8'd0;
                        r_sWren <= 1'b0;
                        r_state <= ST_RD_I;
                    end else begin
                        r_i       <= w_iNext;
                        r_sAddr   <= w_iNext;
                        r_sWrdata <= w_iNext;
                    end
                end
`endif
                ST_RD_I: begin
                    r_state <= ST_LAT_I;
                end
                ST_LAT_I: begin
                    r_si    <= s_rddata;
                    r_j     <= w_jNext;
                    r_sAddr <= w_jNext;
                    r_state <= ST_RD_J;
                end
                ST_RD_J: begin
                    r_state <= ST_LAT_J;
                end
                // The write-data register doubles as the sj holding register
                ST_LAT_J: begin
                    r_sAddr   <= r_i;
                    r_sWrdata <= s_rddata;
                    r_sWren   <= 1'b1;
                    r_state   <= ST_WR_I;
                end
                ST_WR_I: begin
                    r_sAddr   <= r_j;
                    r_sWrdata <= r_si;
                    r_state   <= ST_WR_J;
                end
                ST_WR_J: begin
                    r_sWren <= 1'b0;
                    if (r_i == 8'hFF) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_i     <= w_iNext;
                        r_sAddr <= w_iNext;
                        r_kIdx  <= (r_kIdx == 2'd2) ? 2'd0 : r_kIdx + 2'd1;
                        r_state <= ST_RD_I;
                    end
                end
                ST_DONE: begin
                    r_rdy   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b1;
                    r_sWren <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdy      = r_rdy;
    assign s_addr   = r_sAddr;
    assign s_wrdata = r_sWrdata;
    assign s_wren   = r_sWren;

endmodule

// File: tb/tb_ksa.sv
// Scoreboard bench for ksa: a driver queues expected completions and write traces,
// a monitor checks them against a synchronous S RAM model.
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  sAddr;
    logic [7:0]  sRddata;
    logic [7:0]  sWrdata;
    logic        sWren;

    logic [7:0]  mem [256];
    logic        tbLoad;
    logic [7:0]  tbAddr;
    logic [7:0]  tbData;

`ifdef KSA_INIT_EN
    localparam bit INIT = 1'b1;
    localparam int unsigned LAT = 1794;
`else
    localparam bit INIT = 1'b0;
    localparam int unsigned LAT = 1538;
`endif

    typedef struct {
        int unsigned  latency;
        logic [2047:0] sExp;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    exp_t  expQ [$];
    string nameQ [$];
    wr_t   wrQ [$];

    int errors = 0;
    int checks = 0;
    int unsigned cycleCnt = 0;

    always #5 clk = ~clk;

    ksa dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .key      (key),
        .s_addr   (sAddr),
        .s_rddata (sRddata),
        .s_wrdata (sWrdata),
        .s_wren   (sWren)
    );

    // Synchronous S RAM with a bench-side load port used only while the DUT is idle
    always @(posedge clk) begin
        if (tbLoad) mem[tbAddr] <= tbData;
        else if (sWren) mem[sAddr] <= sWrdata;
        sRddata <= mem[sAddr];
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2047:0] ksaModel(input logic [23:0] k, input logic [2047:0] sIn);
        logic [7:0] s [256];
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        logic [2047:0] r;
        for (int i = 0; i < 256; i++) s[i] = INIT ? 8'(i) : sIn[8*i +: 8];
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = j + s[i] + kb;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int i = 0; i < 256; i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [2047:0] snapMem();
        logic [2047:0] r;
        for (int i = 0; i < 256; i++) r[8*i +: 8] = mem[i];
        return r;
    endfunction

    // Monitor: tracks acceptance on rdy falling, checks latency and final S on rdy rising
    initial begin : monitor
        bit prevRdy;
        int unsigned acceptCycle;
        exp_t e;
        string nm;
        wr_t w;
        logic [2047:0] got;
        int bad;
        int firstBad;
        prevRdy = 1'b1;
        acceptCycle = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prevRdy = 1'b1;
            end else begin
                if (prevRdy && !rdy) acceptCycle = cycleCnt;
                if (!prevRdy && rdy) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected completion: actual=rdy rise required=none");
                    end else begin
                        e  = expQ.pop_front();
                        nm = nameQ.pop_front();
                        checkOutput({nm, " latency"}, cycleCnt - acceptCycle, e.latency);
                        got = snapMem();
                        bad = 0;
                        firstBad = 0;
                        for (int i = 255; i >= 0; i--) begin
                            if (got[8*i +: 8] !== e.sExp[8*i +: 8]) begin
                                bad++;
                                firstBad = i;
                            end
                        end
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("[TB] FAIL %s S contents: %0d bytes differ, S[%0d] actual=%0h required=%0h",
                                     nm, bad, firstBad, got[8*firstBad +: 8], e.sExp[8*firstBad +: 8]);
                        end
                    end
                end
                prevRdy = rdy;
            end
            if (sWren && wrQ.size() > 0) begin
                w = wrQ.pop_front();
                checkOutput("write addr", 32'(sAddr), 32'(w.addr));
                checkOutput("write data", 32'(sWrdata), 32'(w.data));
            end
        end
    end

    task automatic preloadS(input bit useRandom, output logic [2047:0] img);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            tbLoad = 1'b1;
            tbAddr = 8'(i);
            tbData = useRandom ? 8'($urandom_range(0, 255)) : 8'(i);
            img[8*i +: 8] = tbData;
        end
        @(negedge clk);
        tbLoad = 1'b0;
    endtask

    task automatic pushWrite(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wrQ.push_back(w);
    endtask

    task automatic pushFillTrace();
        if (INIT) begin
            for (int i = 0; i < 256; i++) pushWrite(8'(i), 8'(i));
        end
    endtask

    task automatic waitDone(input string name, input int remaining);
        int n;
        n = 0;
        while (expQ.size() > remaining && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: actual=busy after %0d cycles required=done", name, n);
            while (expQ.size() > remaining) begin
                void'(expQ.pop_front());
                void'(nameQ.pop_front());
            end
        end
    endtask

    task automatic applyStimulus(input string name, input logic [23:0] k);
        logic [2047:0] img;
        exp_t e;
        preloadS(INIT, img);
        key = k;
        e.latency = LAT;
        e.sExp = ksaModel(k, img);
        expQ.push_back(e);
        nameQ.push_back(name);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, " rdy fall"}, 32'(rdy), 32'd0);
        en = 1'b0;
        waitDone(name, 0);
    endtask

    initial begin : driver
        logic [2047:0] img;
        exp_t e1;
        exp_t e2;
        rst = 1'b1;
        en = 1'b0;
        key = 24'd0;
        tbLoad = 1'b0;
        tbAddr = 8'd0;
        tbData = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rdy", 32'(rdy), 32'd1);
        checkOutput("reset s_wren", 32'(sWren), 32'd0);
        checkOutput("reset s_addr", 32'(sAddr), 32'd0);
        checkOutput("reset s_wrdata", 32'(sWrdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-traced first four iterations for key 00 01 55 from identity S
        pushFillTrace();
        pushWrite(8'h00, 8'h00); pushWrite(8'h00, 8'h00);
        pushWrite(8'h01, 8'h02); pushWrite(8'h02, 8'h01);
        pushWrite(8'h02, 8'h58); pushWrite(8'h58, 8'h01);
        pushWrite(8'h03, 8'h5B); pushWrite(8'h5B, 8'h03);
        applyStimulus("key000155", 24'h000155);
        checkOutput("trace1 drained", 32'(wrQ.size()), 32'd0);

        applyStimulus("key000000", 24'h000000);

        // i==j on iteration 0 leaves S[0]=0; iteration 1 swaps S[1] with S[0xC4]
        pushFillTrace();
        pushWrite(8'h00, 8'h00); pushWrite(8'h00, 8'h00);
        pushWrite(8'h01, 8'hC4); pushWrite(8'hC4, 8'h01);
        applyStimulus("key00C3E1", 24'h00C3E1);
        checkOutput("trace3 drained", 32'(wrQ.size()), 32'd0);

        // en held high across a run: exactly one back-to-back restart
        preloadS(INIT, img);
        key = 24'h1A2B3C;
        e1.latency = LAT;
        e1.sExp = ksaModel(key, img);
        e2.latency = LAT;
        e2.sExp = ksaModel(key, e1.sExp);
        expQ.push_back(e1); nameQ.push_back("held run1");
        expQ.push_back(e2); nameQ.push_back("held run2");
        @(negedge clk);
        en = 1'b1;
        waitDone("held run1", 1);
        #1;
        checkOutput("held restart", 32'(rdy), 32'd0);
        en = 1'b0;
        waitDone("held run2", 0);

        // Reset 700 cycles into a run
        preloadS(INIT, img);
        key = 24'h55AA33;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (699) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrun reset rdy", 32'(rdy), 32'd1);
        checkOutput("midrun reset s_wren", 32'(sWren), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("after reset", 24'hDEAD01);

        repeat (4) @(posedge clk);
        checkOutput("queue drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ksa.md
# ksa

- Key-scheduling stage of the ARC4 decrypt path; sits directly upstream of `prga`.
- Takes a 24-bit key and permutes the 256-byte S memory in place with the ARC4 KSA: j = j + S[i] + key[i mod 3]; swap S[i], S[j].
- On completion, hands the same S memory to `prga` through the shared en/rdy handshake.
- Optionally performs the identity fill S[i] = i first, so the whole state setup is one block.

## Interface

Parameters:
- none; the key length is fixed at 3 bytes and the S memory depth at 256.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high = idle and ready to accept en.
- key  in  24  ARC4 key; byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0]; must be held stable while busy.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S memory read data; valid the cycle after s_addr is presented (synchronous RAM).
- s_wrdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.

## Operation

FSM states: IDLE, FILL (init build only), RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, DONE.

- IDLE:
  - rdy=1.
  - en=1 → clear i=0, j=0; go to FILL (init build) or RD_I.
- FILL:
  - s_addr=i, s_wrdata=i, s_wren=1; i increments each cycle.
  - After the i=255 write: i=0, go to RD_I.
- RD_I: s_addr=i.
- LAT_I:
  - si ← s_rddata.
  - j ← (j + s_rddata + key byte[i mod 3]) mod 256.
- RD_J: s_addr=j.
- LAT_J: sj ← s_rddata.
- WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
- WR_J:
  - s_addr=j, s_wrdata=si, s_wren=1.
  - i=255 → DONE; else i←i+1, go to RD_I.
- DONE: one cycle, s_wren=0; then IDLE.

Arithmetic and counters:
- All index arithmetic is 8-bit, wrapping modulo 256.
- The i mod 3 selector is a separate 2-bit counter (0,1,2,0…) reset with i; no divider.

Boundary conditions:
- i==j: both writes target the same address with the same value; S is unchanged, as required.
- en while rdy=0: ignored; no queuing.
- Back-to-back: en held high in IDLE starts a new run immediately, with i and j cleared again.
- Reset mid-run:
  - Return to IDLE immediately with rdy=1, s_wren=0.
  - S contents are partial and undefined; the caller must restart.

## Timing

Reset values:
- rdy=1, s_wren=0, s_addr=0, s_wrdata=0.
- i=0, j=0, FSM in IDLE.

Handshake:
- en sampled high at edge E → rdy low from edge E; first active state in cycle E+1.

Latency:
- Each KSA iteration is 6 cycles; 256 iterations = 1536 cycles.
- Last WR_J write at edge E+1536 (E+1792 with init); DONE follows, rdy=1 at edge E+1538 (E+1794 with init).

Outputs and memory port:
- s_wren is asserted only in FILL, WR_I and WR_J.
- s_addr and s_wrdata are registered outputs, valid in the same cycle as s_wren.
- No read is issued in a write state; the RAM never sees a read and a write in the same cycle.

## Configuration

Macro KSA_INIT_EN:
- Defined: the FILL phase runs before the KSA (256 extra cycles). S contents on entry are irrelevant.
- Undefined:
  - The FILL state is not compiled in; IDLE goes straight to RD_I.
  - The caller (`init` block) must have loaded S[i]=i beforehand.

## Test plan

- Key 24'h000155, KSA_INIT_EN defined, S preloaded with random data:
  - Pulse en → rdy falls the next edge and returns exactly 1794 cycles after acceptance.
  - S matches a software KSA model over all 256 entries.
- Key 24'h000000, KSA_INIT_EN undefined, S preloaded with S[i]=i:
  - Final S matches the model.
  - Completion at 1538 cycles.
  - Run `prga` after it on test1.memh; plaintext matches the model.
- Key chosen so iteration 0 gives j=0 (key byte 0 = 0x00): the i==j case leaves S[0]=0 after iteration 0 and the final S still matches the model.
- Hold en=1 for the whole run:
  - No restart while rdy=0.
  - A second run starts on the cycle rdy rises; both runs produce identical S.
- Assert rst at cycle 700 of a run:
  - rdy=1 and s_wren=0 immediately.
  - A new en afterwards gives a correct S (with KSA_INIT_EN defined).
